pipeline_skid_stage: RTL
========================

# pipeline_skid_stage

Parametrised elastic pipeline register with valid/ready handshake and a two-entry (main + skid) buffer. It is the successor to the plain always-write stage register between MIPS pipeline stages. It adds:
- back-pressure (stall) without combinational ready paths;
- synchronous flush that inserts a bubble;
- a configurable bubble value;
- a transfer counter for the performance monitor.

## Interface
Parameters:
- WIDTH, 32, payload width in bits.
- BUBBLE, 0, value driven on out_data whenever the stage holds no valid word (WIDTH bits; e.g. a NOP encoding).
- CNT_WIDTH, 16, width of the output-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discards all held words at the next edge.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  stage can accept a word; driven directly from a register.
- in_data  input  WIDTH  payload from the producer.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  payload to the consumer; registered.
- count  output  2  occupancy (0, 1 or 2).
- xfer_cnt  output  CNT_WIDTH  number of completed output transfers, modulo 2^CNT_WIDTH.

## Operation
- Definitions:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
- Storage:
  - main register drives out_data and out_valid;
  - skid register holds one overflow word (skid_data, skid_valid).
- in_ready = !skid_valid. It is registered, never combinational from out_ready.
- States (encoded by count):
  - EMPTY (0): main invalid, skid invalid.
  - ONE (1): main valid, skid invalid.
  - FULL (2): main valid, skid valid.
- Transitions when flush = 0:
  - EMPTY:
    - in_xfer -> ONE, main <= in_data;
    - otherwise stay.
  - ONE:
    - in_xfer & out_xfer -> ONE, main <= in_data;
    - in_xfer only -> FULL, skid <= in_data;
    - out_xfer only -> EMPTY, main <= BUBBLE;
    - neither -> stay, main held.
  - FULL (in_ready = 0, so in_xfer cannot occur):
    - out_xfer -> ONE, main <= skid_data, skid <= BUBBLE;
    - otherwise stay.
- Flush (priority over all transitions):
  - next state is EMPTY; main and skid are loaded with BUBBLE; in_ready = 1 next cycle.
  - An out_xfer in the flush cycle completes normally: the consumer took the current word and xfer_cnt increments.
  - An in_xfer in the flush cycle is accepted by the handshake but discarded.
- xfer_cnt:
  - increments by 1 on every out_xfer, including during flush;
  - wraps from 2^CNT_WIDTH-1 to 0;
  - cleared only by rst, never by flush.
- Ordering: words leave in the order accepted. There is no duplication and no loss except on flush.

## Timing
- Reset values after the first rising edge with rst = 1:
  - out_valid = 0, out_data = BUBBLE, in_ready = 1, count = 0, xfer_cnt = 0;
  - skid register = BUBBLE, invalid.
- rst has priority over flush and all handshakes; inputs are ignored while rst = 1. Reset mid-operation drops all held words and clears the counter.
- Latency:
  - a word accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1) when the stage was EMPTY, or ONE with a simultaneous out_xfer;
  - otherwise it waits behind the words already held.
- Throughput: 1 word/cycle sustained while out_ready = 1.
- Back-pressure:
  - after out_ready drops, in_ready stays 1 for one more cycle (the skid absorbs one word), then falls to 0;
  - in_ready rises the cycle after the first out_xfer from FULL.
- out_data, out_valid, in_ready, count and xfer_cnt all change only on rising edges. None is combinational from inputs.
- out_data must be stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset: drive rst = 1 for 2 cycles with in_valid = 1, in_data = 32'hDEAD_BEEF -> out_valid = 0, out_data = BUBBLE (0), in_ready = 1, count = 0, xfer_cnt = 0.
- Streaming: out_ready = 1, push 0x1..0x8 on consecutive cycles -> out_data shows 0x1..0x8 one cycle after each accept, count = 1 throughout, xfer_cnt = 8.
- Stall/skid: push 0xA, 0xB, 0xC with out_ready = 0.
  - Required: 0xA in main, 0xB in skid, in_ready = 0, 0xC held by producer, count = 2, out_data stable at 0xA.
  - Then release out_ready: 0xA, 0xB, 0xC emerge in order with no gap after the first; in_ready returns to 1 the cycle after 0xA leaves.
- Flush while FULL: hold 0x11/0x22, assert flush with out_ready = 1 and in_valid = 1, in_data = 0x33.
  - Required: xfer_cnt += 1 (0x11 consumed), next cycle out_valid = 0, out_data = BUBBLE, count = 0, 0x33 never appears.
- Counter wrap: CNT_WIDTH = 4, 17 output transfers -> xfer_cnt = 1; then a flush -> xfer_cnt unchanged; then rst -> xfer_cnt = 0.
- Random: random in_valid/out_ready at 50 % with BUBBLE = 32'h0000_0020 -> scoreboard matches input order exactly, in_ready never depends combinationally on out_ready, out_data = 0x20 whenever out_valid = 0.

Source files
------------

// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register with valid/ready handshake, a main + skid buffer,
// synchronous flush that inserts a bubble, and an output-transfer counter.
module pipeline_skid_stage #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   BUBBLE    = '0,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           count,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  // State value doubles as the occupancy reported on count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]           state_q,    state_d;
  logic [WIDTH-1:0]     main_q,     main_d;
  logic [WIDTH-1:0]     skid_q,     skid_d;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = (state_q != S_EMPTY) & out_ready;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(out_xfer);

    if (flush) begin
      // A word offered in this cycle is handshaken but dropped with the rest.
      state_d = S_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    // Ready is precomputed from the next state so it leaves a flop directly.
    in_ready_d = (state_d != S_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments only; the data
  // registers are reset too because BUBBLE must be visible on out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
